// File: rtl/bcd_xs3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_xs3_pkg
// Description : Shared constants and helpers for the serial BCD/Excess-3
//               converter: mode encoding, serial add constants, range limits.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_xs3_pkg;

  // Runtime conversion direction
  localparam logic MODE_ENC = 1'b0;  // BCD -> XS3 (+3)
  localparam logic MODE_DEC = 1'b1;  // XS3 -> BCD (+13 mod 16)

  // Constant addend patterns, bit k[i] applied to serial bit i
  localparam logic [3:0] K_ENC = 4'b0011;
  localparam logic [3:0] K_DEC = 4'b1101;

  // Legal input code ranges
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;

  // True when a complete input digit code is outside the range for its mode
  function automatic logic code_invalid(input logic m, input logic [3:0] v);
    if (m == MODE_ENC) return (v > BCD_MAX);
    else               return (v < XS3_MIN) || (v > XS3_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_xs3_bit_alu.sv
`default_nettype none
// ============================================================================
// Module      : bcd_xs3_bit_alu
// Description : One serial full-adder step. Selects the constant bit for the
//               current bit position and mode, then adds it to the input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_xs3_bit_alu
  import bcd_xs3_pkg::*;
(
  input  logic       bin,
  input  logic       mode,
  input  logic [1:0] bit_idx,
  input  logic       carry_in,
  output logic       bout,
  output logic       carry_next
);

  logic k;

  // Constant bit for this position of the selected addend
  assign k          = (mode == MODE_DEC) ? K_DEC[bit_idx] : K_ENC[bit_idx];
  assign bout       = bin ^ k ^ carry_in;
  assign carry_next = (bin & k) | (bin & carry_in) | (k & carry_in);

endmodule
`default_nettype wire

// File: rtl/bcd_xs3_serial_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_xs3_serial_conv
// Description : Bit-serial LSB-first BCD <-> Excess-3 converter for frames of
//               NUM_DIGITS digits, with valid/stall handshake, digit/frame
//               markers, range-error flag and one-cycle registered output.
//               Optional macro BCD_XS3_ERRCNT_EN adds a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_xs3_serial_conv
  import bcd_xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bin,
  input  logic                 bin_valid,
  input  logic                 mode,
  output logic                 bout,
  output logic                 bout_valid,
  output logic                 bout_digit_end,
  output logic                 bout_frame_end,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

  logic [1:0]       bit_idx;
  logic [DIG_W-1:0] digit_idx;
  logic             carry;
  logic             mode_q;
  logic [2:0]       shadow;

  logic frame_start;
  logic eff_mode;
  logic carry_in;
  logic alu_bout;
  logic alu_carry;
  logic last_bit;
  logic err_next;

  // A new frame begins on the first bit of digit 0; mode is taken live there
  assign frame_start = (bit_idx == 2'd0) && (digit_idx == '0);
  assign eff_mode    = frame_start ? mode : mode_q;
  assign carry_in    = (bit_idx == 2'd0) ? 1'b0 : carry;
  assign last_bit    = (bit_idx == 2'd3);
  assign err_next    = bin_valid && last_bit && code_invalid(eff_mode, {bin, shadow});

  bcd_xs3_bit_alu u_alu (
    .bin        (bin),
    .mode       (eff_mode),
    .bit_idx    (bit_idx),
    .carry_in   (carry_in),
    .bout       (alu_bout),
    .carry_next (alu_carry)
  );

  // Conversion state and registered outputs; stalls freeze state, zero outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_idx        <= 2'd0;
      digit_idx      <= '0;
      carry          <= 1'b0;
      mode_q         <= MODE_ENC;
      shadow         <= 3'b000;
      bout           <= 1'b0;
      bout_valid     <= 1'b0;
      bout_digit_end <= 1'b0;
      bout_frame_end <= 1'b0;
      err            <= 1'b0;
    end else begin
      bout_valid     <= bin_valid;
      bout           <= 1'b0;
      bout_digit_end <= 1'b0;
      bout_frame_end <= 1'b0;
      err            <= 1'b0;
      if (bin_valid) begin
        if (frame_start) mode_q <= mode;
        bout           <= alu_bout;
        bout_digit_end <= last_bit;
        bout_frame_end <= last_bit && (digit_idx == LAST_DIGIT);
        err            <= err_next;
        carry          <= alu_carry;
        // Shift in from the top so bits 0..2 land in shadow[0..2] by bit 3
        shadow         <= {bin, shadow[2:1]};
        bit_idx        <= bit_idx + 2'd1;
        if (last_bit) begin
          digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
        end
      end
    end
  end

`ifdef BCD_XS3_ERRCNT_EN
  // Saturating count of errored digits, updated together with err
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_next && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_xs3_serial_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_xs3_serial_conv
// Description : Self-checking bench for bcd_xs3_serial_conv (two-digit frames)
//               with directed digits and randomized traffic against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_xs3_serial_conv;

  localparam int ND = 2;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bin = 1'b0;
  logic          bin_valid = 1'b0;
  logic          mode = 1'b0;
  logic          bout;
  logic          bout_valid;
  logic          bout_digit_end;
  logic          bout_frame_end;
  logic          err;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: bits of the digit in progress, digit index, mode
  logic q[$];
  int   fdig = 0;
  logic fmode = 1'b0;
  int   ecnt = 0;

  // Output digit collector (built from what the DUT emits)
  int out_acc = 0;
  int out_n = 0;
  int last_out = -1;
  int last_err = 0;

  always #5 clk = ~clk;

  bcd_xs3_serial_conv #(.NUM_DIGITS(ND), .ERR_CNT_W(EW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bin            (bin),
    .bin_valid      (bin_valid),
    .mode           (mode),
    .bout           (bout),
    .bout_valid     (bout_valid),
    .bout_digit_end (bout_digit_end),
    .bout_frame_end (bout_frame_end),
    .err            (err),
    .err_count      (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bad_code(input logic m, input int v);
    if (!m) return v > 9;
    return (v < 3) || (v > 12);
  endfunction

  // One clock: drive inputs, predict from the model, compare after the edge
  task automatic step(input logic b, input logic v, input logic m, input logic rn);
    logic e_bout, e_valid, e_de, e_fe, e_err;
    int   val, pos;
    e_bout = 0; e_valid = 0; e_de = 0; e_fe = 0; e_err = 0;
    @(negedge clk);
    bin = b; bin_valid = v; mode = m; reset = rn;
    if (!rn) begin
      q.delete(); fdig = 0; fmode = 0; ecnt = 0;
    end else if (v) begin
      if (q.size() == 0 && fdig == 0) fmode = m;
      q.push_back(b);
      val = 0;
      foreach (q[i]) val += int'(q[i]) << i;
      pos = q.size() - 1;
      e_valid = 1;
      e_bout  = 1'(((val + (fmode ? 13 : 3)) % 16) >> pos);
      if (pos == 3) begin
        e_de  = 1;
        e_fe  = (fdig == ND - 1);
        e_err = bad_code(fmode, val);
        if (e_err && ecnt < (1 << EW) - 1) ecnt++;
        q.delete();
        fdig = (fdig + 1) % ND;
      end
    end
    @(posedge clk);
    #1;
    chk("bout_valid", bout_valid, e_valid);
    chk("bout", bout, e_bout);
    chk("digit_end", bout_digit_end, e_de);
    chk("frame_end", bout_frame_end, e_fe);
    chk("err", err, e_err);
`ifdef BCD_XS3_ERRCNT_EN
    chk("err_count", err_count, ecnt);
`else
    chk("err_count", err_count, 0);
`endif
    if (!rn) begin
      out_acc = 0; out_n = 0;
    end else if (bout_valid) begin
      out_acc |= int'(bout) << out_n;
      out_n++;
      if (bout_digit_end) begin
        last_out = out_acc; last_err = int'(err);
        out_acc = 0; out_n = 0;
      end
    end
  endtask

  // Send one 4-bit digit; optional idle gaps after each bit and mode toggling
  task automatic send_digit(input int value, input logic m, input int gap, input logic tog);
    for (int i = 0; i < 4; i++) begin
      step(1'((value >> i) & 1), 1'b1, m ^ (tog & 1'(i)), 1'b1);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, m, 1'b1);
    end
  endtask

  initial begin
    // Reset state
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("rst_bout", bout, 0);

    // Encode 5 -> 8, then complete the frame with 0 -> 3
    send_digit(5, 0, 0, 0);  chk("enc5", last_out, 8);  chk("enc5_err", last_err, 0);
    send_digit(0, 0, 0, 0);  chk("enc0", last_out, 3);
    // Decode 8 -> 5, 12 -> 9
    send_digit(8, 1, 0, 0);  chk("dec8", last_out, 5);
    send_digit(12, 1, 0, 0); chk("dec12", last_out, 9);
    // Encode 47 with stalls between bits
    send_digit(7, 0, 2, 0);  chk("enc7", last_out, 10);
    send_digit(4, 0, 2, 0);  chk("enc4", last_out, 7);
    // Range errors
    send_digit(12, 0, 0, 0); chk("enc12", last_out, 15); chk("enc12_err", last_err, 1);
    send_digit(3, 0, 0, 0);  chk("enc3", last_out, 6);
    send_digit(2, 1, 0, 0);  chk("dec2_err", last_err, 1);
    send_digit(3, 1, 0, 0);  chk("dec3", last_out, 0); chk("dec3_err", last_err, 0);
    // Mode toggling mid-frame is ignored: whole frame stays encode
    send_digit(2, 0, 0, 1);  chk("tog2", last_out, 5);
    send_digit(1, 0, 0, 1);  chk("tog1", last_out, 4);
    // Reset after two bits discards the partial digit
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 0);
    send_digit(5, 0, 0, 0);  chk("post_rst", last_out, 8);

    // Randomized traffic with stalls, mode changes and occasional reset
    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 79) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_xs3_serial_conv.md
Name: bcd_xs3_serial_conv

Overview:
- Bit-serial, LSB-first converter between BCD and Excess-3.
- Handles frames of NUM_DIGITS digits, least-significant digit first.
- Runtime mode selects encode (BCD -> XS3, add 3) or decode (XS3 -> BCD, subtract 3).
- Flags out-of-range digits.
- Successor to the single-digit serial BCD->XS3 converter: adds stall-capable valid handshake, digit/frame markers, bidirectional mode, registered output and error detection.

Parameters:
- NUM_DIGITS, 1, digits per frame (>=1); sets width of digit counter.
- ERR_CNT_W, 8, width of saturating error counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- bin  in  1  serial input bit, LSB of each digit first.
- bin_valid  in  1  bin is meaningful this cycle; low = stall, no state advance.
- mode  in  1  0 = encode BCD->XS3, 1 = decode XS3->BCD; sampled at frame start only.
- bout  out  1  serial output bit, LSB first.
- bout_valid  out  1  bout meaningful this cycle.
- bout_digit_end  out  1  high with bit 3 of each output digit.
- bout_frame_end  out  1  high with bit 3 of last digit of frame.
- err  out  1  high with bit 3 of a digit whose input code was out of range.
- err_count  out  ERR_CNT_W  saturating count of errored digits (optional feature).

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0, bit_idx=0, digit_idx=0, carry=0, mode_q=0, shadow bits cleared. Takes priority over bin_valid, including mid-digit or mid-frame; a partial digit is discarded with no output.
- Latency: exactly 1 cycle. An accepted bin at edge N produces bout/bout_valid registered at edge N; visible until edge N+1. bout_valid = bin_valid delayed 1 cycle.
- Stall: bin_valid==0 freezes bit_idx, digit_idx, carry and shadow bits. bout_valid=0 next cycle; other outputs are don't-care but held at 0.
- Mode latch: when bin_valid==1, bit_idx==0 and digit_idx==0, mode_q <= mode and that cycle uses the new value. Mode changes at any other time are ignored until the next frame.
- Serial arithmetic, constant bit k[bit_idx]:
  - Encode: k = {1,1,0,0} for bits 0..3 (+3).
  - Decode: k = {1,0,1,1} (+13 mod 16, i.e. -3).
  - Carry-in is 0 at bit 0 of every digit.
  - bout = bin ^ k ^ c; c_next = maj(bin,k,c).
  - Carry out of bit 3 is discarded; result is mod 16.
- Validity: bits 0..2 of the current input digit are kept in a shadow register. At bit 3 the full 4-bit input code v is checked.
  - Encode: v > 9 is an error.
  - Decode: v < 3 or v > 12 is an error.
  - err asserts with that digit's bit-3 output. Output bits are still produced mod 16; the frame continues.
- Counters: bit_idx 0..3 wraps to 0. digit_idx increments on each bit-3 accept and wraps from NUM_DIGITS-1 to 0.
  - bout_digit_end marks output bit 3.
  - bout_frame_end marks output bit 3 when digit_idx was NUM_DIGITS-1.
- Back-to-back frames with no idle cycle are legal. mode is re-sampled on the first bit of the next frame.

Optional Feature:
- Macro BCD_XS3_ERRCNT_EN.
- Defined: err_count increments on each err pulse, saturates at all-ones, cleared only by reset.
- Undefined: err_count is tied to 0 and has no counter logic.

Decomposition:
- Package bcd_xs3_pkg holds:
  - Mode encoding constants MODE_ENC=0, MODE_DEC=1.
  - 4-bit constant patterns K_ENC=4'b0011, K_DEC=4'b1101.
  - Range limits BCD_MAX=9, XS3_MIN=3, XS3_MAX=12.
- One sub-module, bcd_xs3_bit_alu: a combinational full-adder plus constant mux (bin, k, carry -> bout, carry_next).

Test Plan:
- Encode 5, bits 1,0,1,0 contiguous -> bout 0,0,0,1 (8) one cycle later; bout_digit_end on 4th output bit; err=0.
- Decode 8, bits 0,0,0,1 with mode=1 -> bout 1,0,1,0 (5); then decode 12 -> 9.
- NUM_DIGITS=2, encode 47, digit 7 first then 4, with bin_valid low 2 cycles between bits -> output digits 10 (0,1,0,1) then 7 (1,1,1,0). bout_valid has matching gaps; bout_frame_end only on the final bit.
- Encode 12 (0,0,1,1) -> bout 1,1,1,1 (15), err on 4th bit. Decode 2 -> err. Decode 3 -> 0, no err. With BCD_XS3_ERRCNT_EN, err_count goes 0->1->2.
- Toggle mode mid-frame -> ignored until next frame start. Reset low after 2 bits -> outputs 0 next cycle; next digit converts correctly from bit 0.
